// File: rtl/instr_prefetch_queue.sv
// Instruction prefetch queue: issues sequential fetches to a variable-latency
// instruction memory and buffers {instruction, PC} pairs for decode.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | no request outstanding; issue one when a FIFO slot is free
// WAIT  | request outstanding; ack pushes the word, may chain next fetch
// DROP  | stale request outstanding after a flush; its ack is discarded
module instr_prefetch_queue #(
   parameter int                    ADDR_WIDTH = 16,
   parameter int                    INST_WIDTH = 32,
   parameter int                    DEPTH      = 4,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
   parameter logic [INST_WIDTH-1:0] NOP_INST   = '0
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    flush,
   input  logic [ADDR_WIDTH-1:0]   redirect_pc,
   input  logic                    stall,
   output logic                    inst_valid,
   output logic [INST_WIDTH-1:0]   inst_out,
   output logic [ADDR_WIDTH-1:0]   inst_pc,
   output logic                    imem_req,
   output logic [ADDR_WIDTH-1:0]   imem_addr,
   input  logic                    imem_ack,
   input  logic [INST_WIDTH-1:0]   imem_rdata,
   output logic [$clog2(DEPTH):0]  count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      DROP = 2'd2
   } state_t;

   state_t                 state;
   logic [ADDR_WIDTH-1:0]  fetch_pc;
   logic [ADDR_WIDTH-1:0]  fetch_pc_inc;
   logic [INST_WIDTH-1:0]  inst_mem [DEPTH];
   logic [ADDR_WIDTH-1:0]  pc_mem   [DEPTH];
   logic [PW-1:0]          wr_ptr;
   logic [PW-1:0]          rd_ptr;
   logic                   push;
   logic                   pop;
   logic [CW-1:0]          count_next;

   // Head is presented straight from storage; empty queue shows a NOP.
   assign inst_valid   = (count != '0);
   assign inst_out     = inst_valid ? inst_mem[rd_ptr] : NOP_INST;
   assign inst_pc      = inst_valid ? pc_mem[rd_ptr] : '0;

   // Flush overrides both push and pop; only acks seen in WAIT carry live data.
   assign push         = (state == WAIT) && imem_ack && !flush;
   assign pop          = inst_valid && !stall && !flush;
   assign count_next   = count + CW'(push) - CW'(pop);
   assign fetch_pc_inc = fetch_pc + ADDR_WIDTH'(1);

   // Queue storage; contents are only meaningful below count, so no reset.
   always_ff @(posedge clk) begin
      if (push) begin
         inst_mem[wr_ptr] <= imem_rdata;
         pc_mem[wr_ptr]   <= imem_addr;
      end
   end

   // Pointers wrap naturally; occupancy kept in its own counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PW'(1);
         if (pop)  rd_ptr <= rd_ptr + PW'(1);
         count <= count_next;
      end
   end

   // Fetch sequencer. A slot is always free for the one outstanding request,
   // so WAIT only chains another fetch if the post-update count leaves room.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         fetch_pc  <= RESET_PC;
         imem_req  <= 1'b0;
         imem_addr <= RESET_PC;
      end else begin
         case (state)
            IDLE: begin
               if (flush) begin
                  fetch_pc <= redirect_pc;
               end else if (count < DEPTH_C) begin
                  state     <= WAIT;
                  imem_req  <= 1'b1;
                  imem_addr <= fetch_pc;
               end
            end
            WAIT: begin
               if (flush) begin
                  fetch_pc <= redirect_pc;
                  if (imem_ack) begin
                     state    <= IDLE;
                     imem_req <= 1'b0;
                  end else begin
                     state <= DROP;
                  end
               end else if (imem_ack) begin
                  fetch_pc <= fetch_pc_inc;
                  if (count_next < DEPTH_C) begin
                     imem_addr <= fetch_pc_inc;
                  end else begin
                     state    <= IDLE;
                     imem_req <= 1'b0;
                  end
               end
            end
            DROP: begin
               if (flush) fetch_pc <= redirect_pc;
               if (imem_ack) begin
                  state    <= IDLE;
                  imem_req <= 1'b0;
               end
            end
            default: begin
               state    <= IDLE;
               imem_req <= 1'b0;
            end
         endcase
      end
   end

endmodule
